min_sec_counter: RTL and testbench

Timekeeping core of the minute-second clock. It divides the system clock into a 1 Hz tick and counts MM:SS from 00:00 to 59:59 with wrap-around. It drives four BCD digits, one to each downstream BCD-to-7-segment decoder. It also provides pause/run, synchronous clear and manual minute/second set while paused.

---
 rtl/min_sec_pkg.sv | 7 +
 rtl/min_sec_counter_bcd_digit.sv | 39 +++
 rtl/min_sec_counter.sv | 87 ++++++++
 tb/tb_min_sec_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/min_sec_pkg.sv
// Shared constants for the MM:SS timekeeping core.
package min_sec_pkg;
   localparam int DIGIT_W      = 4;
   localparam int ONES_MAX     = 9;
   localparam int TENS_MAX     = 5;
   localparam int DEF_TICK_DIV = 50000000;
endpackage

// File: rtl/min_sec_counter_bcd_digit.sv
// One BCD digit that wraps at MAX; carry_out fires when an incoming carry wraps it.
module bcd_digit_counter
   import min_sec_pkg::*;
#(
   parameter int MAX = ONES_MAX
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               carry_in,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry_out
);

   localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(MAX);

   logic [DIGIT_W-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (carry_in) begin
         digit_d = (digit_q == DMAX) ? '0 : digit_q + DIGIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit     = digit_q;
   assign carry_out = carry_in && (digit_q == DMAX);

endmodule

// File: rtl/min_sec_counter.sv
// MM:SS counter: prescaler to a 1 Hz tick, four cascaded BCD digits, pause/clear/set.
module min_sec_counter
   import min_sec_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int CNT_W    = 26
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clr,
   input  logic               inc_sec,
   input  logic               inc_min,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] min_ones,
   output logic [DIGIT_W-1:0] min_tens,
   output logic               tick_1hz,
   output logic               hour_pulse
);

   localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] pre_q, pre_d;
   logic             tick_q, tick_d;
   logic             hour_q, hour_d;

   logic tick_go, set_sec, set_min;
   logic so_ci, mo_ci;
   logic so_co, st_co, mo_co, mt_co;

   // clr outranks both the set pulses and the tick; set pulses only count while paused
   assign tick_go = en && (pre_q == TC) && !clr;
   assign set_sec = !en && inc_sec && !clr;
   assign set_min = !en && inc_min && !clr;

   // Seconds-to-minutes carry is passed only on a tick, so setting seconds never moves minutes
   assign so_ci = tick_go || set_sec;
   assign mo_ci = (tick_go && st_co) || set_min;

   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (en) begin
         pre_d = (pre_q == TC) ? '0 : pre_q + CNT_W'(1);
      end
      tick_d = tick_go;
      hour_d = tick_go && mt_co;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
         hour_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
         hour_q <= hour_d;
      end
   end

   bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .carry_in(so_ci), .digit(sec_ones), .carry_out(so_co)
   );

   bcd_digit_counter #(.MAX(TENS_MAX)) u_sec_tens (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .carry_in(so_co), .digit(sec_tens), .carry_out(st_co)
   );

   bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .carry_in(mo_ci), .digit(min_ones), .carry_out(mo_co)
   );

   bcd_digit_counter #(.MAX(TENS_MAX)) u_min_tens (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .carry_in(mo_co), .digit(min_tens), .carry_out(mt_co)
   );

   assign tick_1hz   = tick_q;
   assign hour_pulse = hour_q;

endmodule

// File: tb/tb_min_sec_counter.sv
// Bench for min_sec_counter: vector table, directed corner sequences, random run vs. time model.
module tb_min_sec_counter;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, clr = 1'b0, inc_sec = 1'b0, inc_min = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       tick_1hz, hour_pulse;

   min_sec_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
      .inc_sec(inc_sec), .inc_min(inc_min),
      .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens),
      .tick_1hz(tick_1hz), .hour_pulse(hour_pulse)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference: elapsed time as a plain second count 0..3599 plus a cycle counter
   int m_secs = 0;
   int m_pre = 0;
   bit m_tick = 0;
   bit m_hour = 0;

   typedef struct {
      bit en; bit clr; bit is; bit im;
      int secs; bit tick; bit hour;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [17:0] vec_of(int secs, bit t, bit h);
      int mm = secs / 60;
      int ss = secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), t, h};
   endfunction

   function automatic logic [17:0] dut_vec();
      return {min_tens, min_ones, sec_tens, sec_ones, tick_1hz, hour_pulse};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_clear();
      m_secs = 0; m_pre = 0; m_tick = 0; m_hour = 0;
   endtask

   task automatic model_step(input bit e, input bit c, input bit is, input bit im);
      m_tick = 0;
      m_hour = 0;
      if (c) begin
         m_secs = 0;
         m_pre  = 0;
      end else if (e) begin
         if (m_pre == TD - 1) begin
            m_pre  = 0;
            m_tick = 1;
            m_hour = (m_secs == 3599);
            m_secs = (m_secs + 1) % 3600;
         end else begin
            m_pre++;
         end
      end else begin
         if (is) m_secs = m_secs - (m_secs % 60) + ((m_secs % 60) + 1) % 60;
         if (im) m_secs = (((m_secs / 60) + 1) % 60) * 60 + (m_secs % 60);
      end
   endtask

   task automatic cycle(input bit e, input bit c, input bit is, input bit im);
      en = e; clr = c; inc_sec = is; inc_min = im;
      @(posedge clk);
      model_step(e, c, is, im);
      #1;
      check("model", dut_vec(), vec_of(m_secs, m_tick, m_hour));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      en = 0; clr = 0; inc_sec = 0; inc_min = 0;
      rst_n = 0;
      model_clear();
      #1;
      check("reset_state", dut_vec(), 18'h0);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   // Runs with en=1 until tick_1hz, reporting on which cycle it rose (0 = never within bound)
   task automatic wait_tick(output int n);
      n = 0;
      for (int k = 1; k <= 12; k++) begin
         cycle(1, 0, 0, 0);
         if (tick_1hz) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic set_time(input int mm, input int ss);
      for (int k = 0; k < mm; k++) cycle(0, 0, 0, 1);
      for (int k = 0; k < ss; k++) cycle(0, 0, 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ticks;
      int last;

      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 0, 0, 0, 1, 1, 0};
      tbl[4]  = '{0, 0, 1, 0, 2, 0, 0};
      tbl[5]  = '{0, 0, 0, 1, 62, 0, 0};
      tbl[6]  = '{0, 0, 1, 1, 123, 0, 0};
      tbl[7]  = '{1, 0, 1, 0, 123, 0, 0};
      tbl[8]  = '{1, 1, 0, 0, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{1, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{1, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{1, 0, 0, 0, 1, 1, 0};

      #2;
      check("async_reset_initial", dut_vec(), 18'h0);
      do_reset();

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].en, tbl[i].clr, tbl[i].is, tbl[i].im);
         check($sformatf("tbl[%0d]", i), dut_vec(), vec_of(tbl[i].secs, tbl[i].tick, tbl[i].hour));
      end

      // 40 enabled cycles from reset: ten evenly spaced ticks, ending at 00:10
      do_reset();
      ticks = 0;
      last = 0;
      for (int k = 1; k <= 40; k++) begin
         cycle(1, 0, 0, 0);
         if (tick_1hz) begin
            check("tick_spacing", k - last, TD);
            last = k;
            ticks++;
         end
         if (k == 40) check("sec_carry_edge", {sec_tens, sec_ones}, 8'h10);
      end
      check("tick_count_40", ticks, 10);
      check("digits_00_10", dut_vec() >> 2, 16'h0010);

      // 00:59 -> 01:00 with no hour pulse
      do_reset();
      set_time(0, 59);
      wait_tick(n);
      check("tick_after_0059", n, TD);
      check("digits_01_00", dut_vec(), vec_of(60, 1, 0));

      // 59:59 -> 00:00 with hour pulse for exactly one cycle
      do_reset();
      set_time(59, 59);
      check("preload_5959", dut_vec(), vec_of(3599, 0, 0));
      wait_tick(n);
      check("tick_after_5959", n, TD);
      check("rollover", dut_vec(), vec_of(0, 1, 1));
      cycle(1, 0, 0, 0);
      check("hour_one_cycle", {tick_1hz, hour_pulse}, 2'b00);

      // Pause mid-second keeps the fraction; inc_sec while running is ignored
      do_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      for (int k = 0; k < 10; k++) begin
         cycle(0, 0, 0, 0);
         check("frozen", dut_vec(), 18'h0);
      end
      cycle(1, 0, 1, 0);
      check("resume_no_inc", dut_vec(), 18'h0);
      cycle(1, 0, 0, 0);
      check("resume_tick", dut_vec(), vec_of(1, 1, 0));

      // clr and inc_min at terminal count: clear wins, no tick, full period follows
      do_reset();
      set_time(12, 34);
      check("preload_1234", dut_vec(), vec_of(754, 0, 0));
      for (int k = 0; k < TD - 1; k++) cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 1);
      check("clr_wins", dut_vec(), 18'h0);
      wait_tick(n);
      check("tick_after_clr", n, TD);

      // Asynchronous reset between edges at 05:07
      do_reset();
      set_time(5, 7);
      check("preload_0507", dut_vec(), vec_of(307, 0, 0));
      en = 1;
      #2;
      rst_n = 0;
      model_clear();
      #1;
      check("async_rst_immediate", dut_vec(), 18'h0);
      @(posedge clk);
      #1;
      check("async_rst_held", dut_vec(), 18'h0);
      rst_n = 1;
      wait_tick(n);
      check("tick_after_release", n, TD);
      check("restart_00_01", dut_vec(), vec_of(1, 1, 0));

      // Random mix of run, pause, set and clear against the time model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom % 4) != 0, ($urandom % 40) == 0,
               ($urandom % 3) == 0, ($urandom % 5) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
